// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit.
// Access sizes, FSM states and the alignment rule.
package lsu_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  // A dword is only a legal access on a 64-bit datapath
  function automatic logic misaligned(
    input logic [2:0] lo,
    input size_e      sz,
    input logic       wide
  );
    logic m;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = lo[0];
      SZ_W:    m = |lo[1:0];
      default: m = !wide || (|lo);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response bundle between core, LSU and memory.
// slave = the LSU, master = the surrounding core and memory.
interface lsu_mem_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic              req_signed_i;
  logic [1:0]        req_size_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_err_o;

  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [XLEN/8-1:0] mem_wstrb_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_resp_valid_i;
  logic [XLEN-1:0]   mem_resp_rdata_i;
  logic              mem_resp_err_i;

  modport slave (
    input  req_valid_i, req_we_i, req_signed_i,
    input  req_size_i, req_addr_i, req_wdata_i,
    output req_ready_o,
    output resp_valid_o, resp_rdata_o, resp_err_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o,
    output mem_wstrb_o, mem_wdata_o,
    input  mem_req_ready_i,
    input  mem_resp_valid_i, mem_resp_rdata_i,
    input  mem_resp_err_i
  );

  modport master (
    output req_valid_i, req_we_i, req_signed_i,
    output req_size_i, req_addr_i, req_wdata_i,
    input  req_ready_o,
    input  resp_valid_o, resp_rdata_o, resp_err_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o,
    input  mem_wstrb_o, mem_wdata_o,
    output mem_req_ready_i,
    output mem_resp_valid_i, mem_resp_rdata_i,
    output mem_resp_err_i
  );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Byte-lane steering: strobes, store shift, misalignment
// and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int LW   = $clog2(NB)
) (
  input  size_e           size,
  input  logic [2:0]      addr_lo,
  input  logic            sgn,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] wdata_lane,
  output logic            misal,
  output logic [XLEN-1:0] rdata_ext
);

  logic [LW-1:0]   lane;
  logic [LW+2:0]   sh;
  logic [NB-1:0]   bmask;
  logic [XLEN-1:0] dmask;
  logic [XLEN-1:0] raw;
  logic            top;

  assign lane  = addr_lo[LW-1:0];
  assign sh    = {lane, 3'b000};
  assign misal = misaligned(addr_lo, size, XLEN == 64);

  // Full-width masks make word-on-32 and dword extension no-ops
  always_comb begin
    bmask = '0;
    dmask = '0;
    top   = 1'b0;
    raw   = rdata >> sh;
    unique case (size)
      SZ_B: begin
        bmask = NB'(1);
        dmask = XLEN'(8'hFF);
        top   = raw[7];
      end
      SZ_H: begin
        bmask = NB'(3);
        dmask = XLEN'(16'hFFFF);
        top   = raw[15];
      end
      SZ_W: begin
        bmask = NB'(4'hF);
        dmask = XLEN'(32'hFFFF_FFFF);
        top   = raw[31];
      end
      default: begin
        bmask = '1;
        dmask = '1;
        top   = raw[XLEN-1];
      end
    endcase
    wstrb      = bmask << lane;
    wdata_lane = wdata << sh;
    rdata_ext  = (raw & dmask)
               | ((sgn && top) ? ~dmask : '0);
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: one outstanding access, handshaked
// memory port, response timeout and one-cycle result pulse.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input logic           clk_i,
  input logic           rst_i,
  lsu_mem_ctrl_if.slave bus
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  state_e state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic              sgn_q;
  size_e             size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;

  logic            idle;
  logic            tmo;
  size_e           a_size;
  logic [2:0]      a_lo;
  logic [NB-1:0]   wstrb;
  logic [XLEN-1:0] wlane;
  logic [XLEN-1:0] rext;
  logic            misal;

  assign idle = state == IDLE;
  assign tmo  = cnt == CNT_W'(TIMEOUT - 1);

  // While idle the aligner judges the incoming request
  always_comb begin
    a_size = size_q;
    a_lo   = addr_q[2:0];
    if (idle) begin
      a_size = size_e'(bus.req_size_i);
      a_lo   = bus.req_addr_i[2:0];
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size       (a_size),
    .addr_lo    (a_lo),
    .sgn        (sgn_q),
    .wdata      (wdata_q),
    .rdata      (bus.mem_resp_rdata_i),
    .wstrb      (wstrb),
    .wdata_lane (wlane),
    .misal      (misal),
    .rdata_ext  (rext)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.req_valid_i)
          state_nxt = misal ? DONE : REQ;
      REQ:
        if (bus.mem_req_ready_i) state_nxt = WAIT;
      WAIT:
        if (bus.mem_resp_valid_i || tmo)
          state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid_i) begin
          we_q    <= bus.req_we_i;
          sgn_q   <= bus.req_signed_i;
          size_q  <= size_e'(bus.req_size_i);
          addr_q  <= bus.req_addr_i;
          wdata_q <= bus.req_wdata_i;
          err_q   <= misal;
          rdata_q <= '0;
          cnt     <= '0;
        end
        WAIT: begin
          cnt <= cnt + CNT_W'(1);
          // A response in the timeout cycle still wins
          if (bus.mem_resp_valid_i) begin
            err_q   <= bus.mem_resp_err_i;
            rdata_q <= (we_q || bus.mem_resp_err_i)
                     ? '0 : rext;
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o     = idle;
  assign bus.mem_req_valid_o = state == REQ;
  assign bus.mem_we_o        = (state == REQ) && we_q;
  assign bus.mem_addr_o      = {addr_q[ADDR_W-1:LW], LW'(0)};
  assign bus.mem_wdata_o     = wlane;
  assign bus.mem_wstrb_o     = (state != REQ) ? '0
                             : (we_q ? wstrb : '1);

  assign bus.resp_valid_o = state == DONE;
  assign bus.resp_rdata_o = (state == DONE) ? rdata_q : '0;
  assign bus.resp_err_o   = (state == DONE) && err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random
// accesses against a byte-level reference model.
module tb_lsu_mem_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.XLEN(32), .ADDR_W(32)) bus ();

  lsu_mem_ctrl #(
    .XLEN(32), .ADDR_W(32), .TIMEOUT(TMO), .CNT_W(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(
    input logic [31:0] word,
    input int          size,
    input logic [31:0] addr,
    input bit          sgn
  );
    longint unsigned v, mask;
    int nbits;
    nbits = 8 * (1 << size);
    v     = longint'(word) >> (8 * (addr % 4));
    mask  = (64'd1 << nbits) - 1;
    v     = v & mask;
    if (sgn && ((v >> (nbits - 1)) & 1) == 1)
      v = v | ~mask;
    return v[31:0];
  endfunction

  // nresp < 0: memory never answers
  task automatic run_txn(
    input bit          we,
    input bit          sgn,
    input int          size,
    input logic [31:0] addr,
    input logic [31:0] wdata,
    input logic [31:0] word,
    input bit          merr,
    input int          rd,
    input int          nresp
  );
    bit          mis, in_wait, go_wait, done;
    int          nb, lane, exp_lat, lat, rdy, wcnt, reqs;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    logic        exp_err;
    nb   = 1 << size;
    lane = addr % 4;
    mis  = (size == 3) || (addr % nb != 0);
    exp_wd   = wdata << (8 * lane);
    exp_strb = we ? 4'(((1 << nb) - 1) << lane) : 4'hF;
    if (mis) begin
      exp_lat = 1; exp_err = 1'b1; exp_rd = '0;
    end else if (nresp < 0) begin
      exp_lat = 2 + rd + TMO; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_lat = 3 + rd + nresp;
      exp_err = merr;
      exp_rd  = (we || merr) ? '0
              : model_load(word, size, addr, sgn);
    end
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = we;
    bus.req_signed_i = sgn;
    bus.req_size_i   = 2'(size);
    bus.req_addr_i   = addr;
    bus.req_wdata_i  = wdata;
    @(negedge clk);
    check("req_ready", bus.req_ready_o, 1);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    in_wait = 0; done = 0; lat = -1;
    rdy = 0; wcnt = 0; reqs = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      bus.mem_resp_valid_i = in_wait && nresp >= 0
                          && wcnt == nresp;
      bus.mem_resp_rdata_i = bus.mem_resp_valid_i
                           ? word : $urandom;
      bus.mem_resp_err_i   = bus.mem_resp_valid_i
                           ? merr : 1'($urandom);
      @(negedge clk);
      go_wait = 0;
      bus.mem_req_ready_i = 1'b0;
      if (bus.mem_req_valid_o) begin
        reqs++;
        check("mem_addr", bus.mem_addr_o, addr & ~32'h3);
        check("mem_we", bus.mem_we_o, we);
        check("mem_wstrb", bus.mem_wstrb_o, exp_strb);
        if (we) check("mem_wdata", bus.mem_wdata_o, exp_wd);
        go_wait = rdy == rd;
        bus.mem_req_ready_i = go_wait;
        rdy++;
      end
      if (bus.resp_valid_o) begin
        done = 1; lat = c;
        check("resp_rdata", bus.resp_rdata_o, exp_rd);
        check("resp_err", bus.resp_err_o, exp_err);
      end
      @(posedge clk); #1;
      bus.mem_req_ready_i = 1'b0;
      if (in_wait) wcnt++;
      if (go_wait) begin in_wait = 1; wcnt = 0; end
    end
    check("resp_seen", done, 1);
    check("latency", lat, exp_lat);
    check("mem_reqs", reqs, mis ? 0 : rd + 1);
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_err_i   = 1'b0;
    @(negedge clk);
    check("pulse_end", bus.resp_valid_o, 0);
    check("idle_ready", bus.req_ready_o, 1);
    check("idle_rdata", bus.resp_rdata_o, 0);
    @(posedge clk); #1;
  endtask

  task automatic reset_in_wait();
    bus.req_valid_i  = 1'b1;
    bus.req_we_i     = 1'b0;
    bus.req_signed_i = 1'b0;
    bus.req_size_i   = 2'd2;
    bus.req_addr_i   = 32'h5000;
    @(posedge clk); #1;
    bus.req_valid_i     = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    check("wait_busy", bus.req_ready_o, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_resp_valid_i = 1'b1;
    bus.mem_resp_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_ready", bus.req_ready_o, 1);
    check("rst_mreq", bus.mem_req_valid_o, 0);
    @(posedge clk); #1;
    bus.mem_resp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_resp", bus.resp_valid_o, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int sz, r, nr;
    logic [31:0] a;
    bus.req_valid_i      = 1'b0;
    bus.req_we_i         = 1'b0;
    bus.req_signed_i     = 1'b0;
    bus.req_size_i       = '0;
    bus.req_addr_i       = '0;
    bus.req_wdata_i      = '0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_resp_valid_i = 1'b0;
    bus.mem_resp_rdata_i = '0;
    bus.mem_resp_err_i   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_resp_rdata", bus.resp_rdata_o, 0);
    check("rst_resp_err", bus.resp_err_o, 0);
    check("rst_mem_valid", bus.mem_req_valid_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_wstrb", bus.mem_wstrb_o, 0);
    @(posedge clk); #1;

    run_txn(0, 1, 0, 32'h1003, 0, 32'h80FF_1234, 0, 0, 0);
    run_txn(0, 0, 1, 32'h2002, 0, 32'h8001_0000, 0, 0, 0);
    run_txn(1, 0, 0, 32'h3001, 32'hAB, 0, 0, 4, 0);
    run_txn(0, 0, 2, 32'h4002, 0, 0, 0, 0, 0);
    run_txn(0, 0, 2, 32'h4000, 0, 0, 0, 0, -1);
    run_txn(0, 1, 1, 32'h4006, 0, 32'h9876_5432, 0, 1, 3);
    run_txn(0, 0, 3, 32'h4008, 0, 0, 0, 0, 0);
    reset_in_wait();
    run_txn(0, 1, 2, 32'h6004, 0, 32'hC001_D00D, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      sz = $urandom_range(0, 3);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = a & ~32'((1 << sz) - 1);
      r  = $urandom_range(0, 5);
      nr = (r == 5) ? -1 : r % 4;
      run_txn(1'($urandom), 1'($urandom), sz, a,
              $urandom, $urandom,
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 3), nr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Parametrised load/store unit with handshakes on both sides.
- Upstream, it accepts one load or store per transaction from the execute stage over a valid/ready request channel.
- Downstream, it drives a word-addressed memory port that accepts requests over valid/ready and may respond after a variable number of cycles. This replaces zero-latency DPI memory access.
- Handles byte-lane alignment, sign/zero extension, misalignment detection and a response timeout, and returns the result on a one-cycle response pulse.

Parameters:
- XLEN, 32, data width in bits; must be 32 or 64.
- ADDR_W, 32, address width in bits.
- TIMEOUT, 255, maximum cycles spent in WAIT before the transaction is aborted with an error; must be ≥1.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  upstream request valid.
- req_ready_o  out  1  unit can accept a request.
- req_we_i  in  1  1 = store, 0 = load.
- req_signed_i  in  1  sign-extend load data.
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword (dword legal only when XLEN=64).
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  XLEN  store data, right-aligned.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- resp_err_o  out  1  misaligned access, memory error or timeout.
- mem_req_valid_o  out  1  memory request valid.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  address with the low log2(XLEN/8) bits cleared.
- mem_wstrb_o  out  XLEN/8  byte strobes.
- mem_wdata_o  out  XLEN  store data shifted onto its byte lanes.
- mem_resp_valid_i  in  1  memory response or write acknowledge.
- mem_resp_rdata_i  in  XLEN  raw memory word.
- mem_resp_err_i  in  1  memory error, qualified by mem_resp_valid_i.

Behaviour:
- Reset (synchronous, rst_i=1 at a clk_i edge):
  - State goes to IDLE; the timeout counter and all registered fields clear.
  - After the reset edge: req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, mem_req_valid_o=0, mem_we_o=0, mem_wstrb_o=0.
  - A reset asserted mid-transaction abandons it with no response. A mem_resp_valid_i arriving later while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
  - req_ready_o = (state==IDLE). The request fields are registered on req_valid_i && req_ready_o.
- IDLE accept:
  - Misaligned accesses go straight to DONE with resp_err_o=1 and no memory request. Misaligned means the address is not a multiple of the access size, or size=3 with XLEN=32.
  - All other accesses go to REQ.
- REQ:
  - mem_req_valid_o=1. mem_addr_o, mem_we_o, mem_wstrb_o and mem_wdata_o are held stable until mem_req_ready_i=1, then the state moves to WAIT.
  - There is no timeout in REQ.
- WAIT:
  - The counter increments each cycle.
  - On mem_resp_valid_i: capture data and error, then go to DONE.
  - If the counter reaches TIMEOUT without a response: go to DONE with resp_err_o=1.
  - If mem_resp_valid_i and the timeout coincide, the response wins.
  - Memory responses are sampled only in WAIT.
- DONE:
  - resp_valid_o=1 for exactly one cycle, then IDLE. resp_rdata_o and resp_err_o are valid only in that cycle and are 0 otherwise.
- Strobe and lane mapping:
  - mem_wstrb_o = ((1<<(1<<size))-1) << lane, where lane = addr mod (XLEN/8).
  - mem_wdata_o = wdata << (8*lane).
  - Loads drive full strobes.
- Load extraction:
  - Shift mem_resp_rdata_i right by 8*lane, then mask to the access size.
  - Sign-extend from the top bit of the access when req_signed_i=1, otherwise zero-extend.
  - For a word access with XLEN=32, no extension is applied.
- Stores complete on the memory acknowledge (mem_resp_valid_i) and return resp_rdata_o=0.
- Latency: with memory ready immediately and a response N cycles after WAIT entry, resp_valid_o asserts N+3 cycles after the accept edge. The minimum is 3 cycles (accept → REQ → WAIT → DONE).
- A misaligned access gives resp_valid_o exactly 1 cycle after accept.
- Throughput: one outstanding transaction at a time.

Decomposition:
- Shared package lsu_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D);
  - FSM state enum;
  - XLEN/ADDR_W defaults;
  - a misalignment-check function.
- One combinational sub-module, lsu_align, computes strobe, write-lane shift, misalignment flag and load extraction/extension.
- lsu_mem_ctrl holds the FSM, registers and timeout counter.

Test Plan:
- Aligned signed byte load: addr 0x1003, memory returns 0x80FF_1234 with 0 wait cycles → mem_addr_o=0x1000; resp_rdata_o=0xFFFF_FF80, err=0, 3 cycles after accept.
- Unsigned half load: addr 0x2002, memory returns 0x8001_0000 → resp_rdata_o=0x0000_8001.
- Byte store: addr 0x3001, wdata 0xAB, mem_req_ready_i held low for 4 cycles → mem_wstrb_o=4'b0010 and mem_wdata_o=0x0000_AB00, held stable for 5 cycles; resp_rdata_o=0 on ack.
- Misaligned word load: addr 0x4002 → no mem_req_valid_o, resp_valid_o+resp_err_o 1 cycle after accept.
- Timeout: TIMEOUT=4, memory never responds → resp_err_o=1 after 4 WAIT cycles; req_ready_o back to 1 the next cycle.
- Reset asserted in WAIT, then a late mem_resp_valid_i → no resp_valid_o; the next request completes normally.
